// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared FSM encoding and address-split width helpers for wb_cache
package cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_ALLOCATE  = 2'd2,
        ST_UPDATE    = 2'd3
    } cache_state_e;

    // Bits selecting a word within a block
    function automatic int offset_width(input int words);
        return $clog2(words);
    endfunction

    // Bits selecting a cache line
    function automatic int index_width(input int lines);
        return $clog2(lines);
    endfunction

    // Remaining upper address bits stored as the tag
    function automatic int tag_width(input int addr_w, input int lines, input int words);
        return addr_w - $clog2(lines) - $clog2(words);
    endfunction

endpackage

// File: rtl/cache_ctrl_fsm.sv
// rtl/cache_ctrl_fsm.sv - miss-handling controller sequencing write-back, fetch and line update
module cache_ctrl_fsm
    import cache_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         miss_i,
    input  logic         victim_dirty_i,
    input  logic         mem_busywait_i,
    output cache_state_e state_o,
    output logic         mem_read_o,
    output logic         mem_write_o
);

    cache_state_e state_q;
    logic         mem_read_q;
    logic         mem_write_q;

    // State and memory strobes move together so the strobes are glitch-free registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (miss_i) begin
                        if (victim_dirty_i) begin
                            state_q     <= ST_WRITEBACK;
                            mem_write_q <= 1'b1;
                        end else begin
                            state_q    <= ST_ALLOCATE;
                            mem_read_q <= 1'b1;
                        end
                    end
                end
                ST_WRITEBACK: begin
                    if (!mem_busywait_i) begin
                        state_q     <= ST_ALLOCATE;
                        mem_write_q <= 1'b0;
                        mem_read_q  <= 1'b1;
                    end
                end
                ST_ALLOCATE: begin
                    if (!mem_busywait_i) begin
                        state_q    <= ST_UPDATE;
                        mem_read_q <= 1'b0;
                    end
                end
                ST_UPDATE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                end
            endcase
        end
    end

    assign state_o     = state_q;
    assign mem_read_o  = mem_read_q;
    assign mem_write_o = mem_write_q;

endmodule

// File: rtl/wb_cache.sv
// rtl/wb_cache.sv - direct-mapped write-back write-allocate cache with line storage and hit logic
module wb_cache
    import cache_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LINES  = 8,
    parameter int WORDS  = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               read,
    input  logic                               write,
    input  logic [ADDR_W-1:0]                  address,
    input  logic [DATA_W-1:0]                  writedata,
    output logic [DATA_W-1:0]                  readdata,
    output logic                               busywait,
    output logic                               mem_read,
    output logic                               mem_write,
    output logic [ADDR_W-$clog2(WORDS)-1:0]    mem_address,
    output logic [WORDS*DATA_W-1:0]            mem_writedata,
    input  logic [WORDS*DATA_W-1:0]            mem_readdata,
    input  logic                               mem_busywait
);

    localparam int OFF_W = offset_width(WORDS);
    localparam int IDX_W = index_width(LINES);
    localparam int TAG_W = tag_width(ADDR_W, LINES, WORDS);
    localparam int BLK_W = WORDS * DATA_W;

    logic [OFF_W-1:0] off;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;

    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] dirty_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [BLK_W-1:0] data_q [LINES];

    // Line being refilled; latched so a request that changes mid-miss cannot redirect it
    logic [IDX_W-1:0] miss_idx_q;
    logic [TAG_W-1:0] miss_tag_q;
    logic [BLK_W-1:0] blk_q;

    cache_state_e state;
    logic         in_idle;
    logic         req;
    logic         hit;
    logic         miss;
    logic         victim_dirty;
    logic         write_hit;
    logic         read_hit;

    assign off = address[OFF_W-1:0];
    assign idx = address[OFF_W +: IDX_W];
    assign tag = address[ADDR_W-1 -: TAG_W];

    assign in_idle      = (state == ST_IDLE);
    assign req          = read | write;
    assign hit          = valid_q[idx] && (tag_q[idx] == tag);
    assign miss         = in_idle && req && !hit;
    assign victim_dirty = valid_q[idx] && dirty_q[idx];
    // A simultaneous read and write is served as a write
    assign write_hit    = in_idle && write && hit;
    assign read_hit     = in_idle && read && !write && hit;

    cache_ctrl_fsm u_ctrl (
        .clk            (clk),
        .reset          (reset),
        .miss_i         (miss),
        .victim_dirty_i (victim_dirty),
        .mem_busywait_i (mem_busywait),
        .state_o        (state),
        .mem_read_o     (mem_read),
        .mem_write_o    (mem_write)
    );

    // Stall while a miss is pending; reset releases the CPU at once
    assign busywait = reset && (miss || !in_idle);

    assign readdata = (reset && read_hit) ? data_q[idx][int'(off)*DATA_W +: DATA_W] : '0;

    // Memory address and victim data are only presented during the matching transaction
    always_comb begin
        mem_address   = '0;
        mem_writedata = '0;
        if (state == ST_WRITEBACK) begin
            mem_address   = {tag_q[miss_idx_q], miss_idx_q};
            mem_writedata = data_q[miss_idx_q];
        end else if (state == ST_ALLOCATE) begin
            mem_address = {miss_tag_q, miss_idx_q};
        end
    end

    // Latch the missing line on entry to the miss and capture the fetched block
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            miss_idx_q <= '0;
            miss_tag_q <= '0;
            blk_q      <= '0;
        end else begin
            if (miss) begin
                miss_idx_q <= idx;
                miss_tag_q <= tag;
            end
            if (state == ST_ALLOCATE && !mem_busywait) begin
                blk_q <= mem_readdata;
            end
        end
    end

    // Line status bits: refill makes a line valid and clean, a write hit makes it dirty
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (state == ST_UPDATE) begin
            valid_q[miss_idx_q] <= 1'b1;
            dirty_q[miss_idx_q] <= 1'b0;
        end else if (write_hit) begin
            dirty_q[idx] <= 1'b1;
        end
    end

    // Tag and data storage; contents are meaningless until the valid bit is set
    always_ff @(posedge clk) begin
        if (state == ST_UPDATE) begin
            tag_q[miss_idx_q]  <= miss_tag_q;
            data_q[miss_idx_q] <= blk_q;
        end else if (write_hit) begin
            data_q[idx][int'(off)*DATA_W +: DATA_W] <= writedata;
        end
    end

endmodule

// File: tb/tb_wb_cache.sv
// tb/tb_wb_cache.sv - self-checking bench for wb_cache with a behavioural memory and cache model
module tb_wb_cache;

    logic         clk;
    logic         reset;
    logic         read;
    logic         write;
    logic [31:0]  address;
    logic [31:0]  writedata;
    logic [31:0]  readdata;
    logic         busywait;
    logic         mem_read;
    logic         mem_write;
    logic [29:0]  mem_address;
    logic [127:0] mem_writedata;
    logic [127:0] mem_readdata;
    logic         mem_busywait;

    int tests_run = 0;
    int tests_failed = 0;

    wb_cache dut (
        .clk           (clk),
        .reset         (reset),
        .read          (read),
        .write         (write),
        .address       (address),
        .writedata     (writedata),
        .readdata      (readdata),
        .busywait      (busywait),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Main memory: untouched blocks hold a pattern derived from the block address
    logic [127:0] mem [bit [29:0]];
    int           mem_cnt = 0;

    function automatic logic [127:0] mem_get(input logic [29:0] b);
        logic [127:0] r;
        if (mem.exists(b)) return mem[b];
        for (int w = 0; w < 4; w++) r[w*32 +: 32] = 32'hA000_0000 | (32'(b) << 4) | 32'(w);
        return r;
    endfunction

    // Each transaction is stalled for two cycles, then completes on the third edge
    assign mem_busywait = (mem_read || mem_write) && (mem_cnt != 2);

    always @(posedge clk) begin
        mem_readdata <= mem_get(mem_address);
        if (mem_read || mem_write) begin
            if (mem_cnt == 2) begin
                if (mem_write) mem[mem_address] = mem_writedata;
                mem_cnt <= 0;
            end else begin
                mem_cnt <= mem_cnt + 1;
            end
        end else begin
            mem_cnt <= 0;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // The memory side must never see a read and a write strobe together
    always @(negedge clk) begin
        tests_run++;
        assert (!(mem_read === 1'b1 && mem_write === 1'b1)) else begin
            tests_failed++;
            $error("FAIL mem_excl observed=%0b%0b expected=not both", mem_read, mem_write);
        end
    end

    // One CPU access held until served; records the memory traffic it caused
    task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                          output bit stalled, output bit saw_wr, output bit saw_rd,
                          output logic [29:0] wb_addr, output logic [29:0] alloc_addr,
                          output logic [127:0] wb_data, output logic [31:0] rdata);
        int n;
        @(negedge clk);
        read = rd; write = wr; address = a; writedata = d;
        #1;
        stalled = busywait;
        saw_wr = 0; saw_rd = 0; wb_addr = '0; alloc_addr = '0; wb_data = '0;
        n = 0;
        while (busywait && n < 40) begin
            @(posedge clk); #1;
            if (mem_write && !saw_wr) begin saw_wr = 1; wb_addr = mem_address; wb_data = mem_writedata; end
            if (mem_read && !saw_rd) begin saw_rd = 1; alloc_addr = mem_address; end
            n++;
        end
        chk("served_in_time", {127'b0, busywait}, 128'd0);
        rdata = readdata;
        @(posedge clk); #1;
        read = 0; write = 0;
    endtask

    bit           st, sw, sr;
    logic [29:0]  wa, aa;
    logic [127:0] wd;
    logic [31:0]  rdv;

    logic [31:0]  img [64];
    bit           m_v [8];
    bit           m_d [8];
    int           m_t [8];

    initial begin
        reset = 1'b0; read = 0; write = 0; address = '0; writedata = '0;
        mem[30'd0] = {32'h44, 32'h33, 32'h22, 32'h11};
        #1;
        chk("rst_busywait", {127'b0, busywait}, 128'd0);
        chk("rst_readdata", {96'b0, readdata}, 128'd0);
        chk("rst_mem_read", {127'b0, mem_read}, 128'd0);
        chk("rst_mem_write", {127'b0, mem_write}, 128'd0);
        chk("rst_mem_address", {98'b0, mem_address}, 128'd0);
        chk("rst_mem_writedata", mem_writedata, 128'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Cold miss fetches block 0
        access(1, 0, 32'h1, 0, st, sw, sr, wa, aa, wd, rdv);
        chk("cold_stall", {127'b0, st}, 128'd1);
        chk("cold_mem_read", {127'b0, sr}, 128'd1);
        chk("cold_no_wb", {127'b0, sw}, 128'd0);
        chk("cold_addr", {98'b0, aa}, 128'd0);
        chk("cold_rdata", {96'b0, rdv}, 128'h22);

        // Read hit, same block
        access(1, 0, 32'h2, 0, st, sw, sr, wa, aa, wd, rdv);
        chk("hit_stall", {127'b0, st}, 128'd0);
        chk("hit_no_mem", {126'b0, sw, sr}, 128'd0);
        chk("hit_rdata", {96'b0, rdv}, 128'h33);

        // Write hit then read back
        access(0, 1, 32'h1, 32'hDEADBEEF, st, sw, sr, wa, aa, wd, rdv);
        chk("whit_stall", {127'b0, st}, 128'd0);
        access(1, 0, 32'h1, 0, st, sw, sr, wa, aa, wd, rdv);
        chk("whit_readback", {96'b0, rdv}, 128'hDEADBEEF);

        // Conflict miss on a dirty line: write-back then allocate
        access(1, 0, 32'h21, 0, st, sw, sr, wa, aa, wd, rdv);
        chk("wb_seen", {127'b0, sw}, 128'd1);
        chk("wb_addr", {98'b0, wa}, 128'd0);
        chk("wb_word1", {96'b0, wd[63:32]}, 128'hDEADBEEF);
        chk("wb_block", wd, {32'h44, 32'h33, 32'hDEADBEEF, 32'h11});
        chk("wb_alloc_addr", {98'b0, aa}, 128'd8);
        chk("wb_rdata", {96'b0, rdv}, 128'hA000_0081);

        // Reset in the middle of an allocate
        @(negedge clk);
        read = 1; address = 32'h1;
        #1;
        chk("mid_stall", {127'b0, busywait}, 128'd1);
        @(posedge clk); #1;
        chk("mid_alloc", {127'b0, mem_read}, 128'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_mem_read", {127'b0, mem_read}, 128'd0);
        chk("mid_rst_busywait", {127'b0, busywait}, 128'd0);
        chk("mid_rst_addr", {98'b0, mem_address}, 128'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("post_rst_miss", {127'b0, busywait}, 128'd1);
        access(1, 0, 32'h1, 0, st, sw, sr, wa, aa, wd, rdv);
        chk("post_rst_mem_read", {127'b0, sr}, 128'd1);
        chk("post_rst_no_wb", {127'b0, sw}, 128'd0);
        chk("post_rst_rdata", {96'b0, rdv}, 128'hDEADBEEF);

        // Read and write together behave as a write
        access(1, 1, 32'h2, 32'h55, st, sw, sr, wa, aa, wd, rdv);
        chk("rw_stall", {127'b0, st}, 128'd0);
        chk("rw_rdata_zero", {96'b0, rdv}, 128'd0);
        access(1, 0, 32'h2, 0, st, sw, sr, wa, aa, wd, rdv);
        chk("rw_readback", {96'b0, rdv}, 128'h55);

        // Fresh start for the randomized run; the model sees memory as the cache sees it
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        for (int a = 0; a < 64; a++) begin
            logic [127:0] b;
            b = mem_get(30'(a >> 2));
            img[a] = b[(a % 4)*32 +: 32];
        end
        for (int i = 0; i < 8; i++) begin m_v[i] = 0; m_d[i] = 0; m_t[i] = 0; end

        for (int k = 0; k < 250; k++) begin
            int   a, ix, tg, op;
            bit   rd, wr, hit;
            logic [31:0]  d;
            logic [127:0] exp_blk;
            a  = int'($urandom_range(0, 63));
            ix = (a >> 2) % 8;
            tg = a >> 5;
            op = int'($urandom_range(0, 9));
            rd = (op < 5) || (op == 9);
            wr = (op >= 5);
            d  = $urandom;
            hit = m_v[ix] && (m_t[ix] == tg);
            for (int w = 0; w < 4; w++) exp_blk[w*32 +: 32] = img[m_t[ix]*32 + ix*4 + w];
            access(rd, wr, 32'(a), d, st, sw, sr, wa, aa, wd, rdv);
            chk($sformatf("rnd%0d_stall", k), {127'b0, st}, {127'b0, !hit});
            chk($sformatf("rnd%0d_wb", k), {127'b0, sw}, {127'b0, (!hit && m_v[ix] && m_d[ix])});
            if (!hit && m_v[ix] && m_d[ix]) begin
                chk($sformatf("rnd%0d_wb_addr", k), {98'b0, wa}, 128'(m_t[ix]*8 + ix));
                chk($sformatf("rnd%0d_wb_data", k), wd, exp_blk);
            end
            if (!hit) chk($sformatf("rnd%0d_alloc_addr", k), {98'b0, aa}, 128'(a >> 2));
            chk($sformatf("rnd%0d_rdata", k), {96'b0, rdv}, (rd && !wr) ? {96'b0, img[a]} : 128'd0);
            if (!hit) begin m_v[ix] = 1; m_t[ix] = tg; m_d[ix] = 0; end
            if (wr) begin img[a] = d; m_d[ix] = 1; end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
